// File: rtl/led_pkg.sv
// Shared constants for the led_flash responder: state encoding, default flash
// timing and the initiator's fs timeout.
package led_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ON   = 2'd1;
    localparam state_t OFF  = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam logic [31:0] TIME_ON_DEF  = 32'd5_000_000;
    localparam logic [31:0] TIME_OFF_DEF = 32'd5_000_000;

    // A full run, NUM_FLASH*(TIME_ON+TIME_OFF)+1 cycles, must stay below this.
    localparam logic [31:0] TIME_FS_MAX  = 32'd50_000_000;

endpackage

// File: rtl/led_flash.sv
// Responder side of the fs/fd handshake: on fs, walks a lit LED across the bus
// NUM_FLASH times, then raises fd until the initiator drops fs.
module led_flash
    import led_pkg::*;
#(
    parameter logic [31:0] TIME_ON   = TIME_ON_DEF,
    parameter logic [31:0] TIME_OFF  = TIME_OFF_DEF,
    parameter int          NUM_FLASH = 4,
    parameter int          LED_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fs,
    output logic             fd,
    output logic [LED_W-1:0] led
);

    localparam int IDX_W = (NUM_FLASH > 1) ? $clog2(NUM_FLASH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLASH - 1);

    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Flash index wraps onto the LED bus when there are more flashes than LEDs.
    function automatic logic [LED_W-1:0] onehot(input logic [IDX_W-1:0] idx);
        return LED_W'(1) << (int'(idx) % LED_W);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (fs) state_d = ON;
            end
            ON: begin
                // An fs drop (initiator timeout) wins over the terminal count.
                if (!fs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == TIME_ON - 32'd1) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            end
            OFF: begin
                if (!fs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == TIME_OFF - 32'd1) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = ON;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_d = '0;
                if (!fs) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        fd  = (state_q == DONE);
        led = (state_q == ON) ? onehot(idx_q) : '0;
    end

endmodule

// File: tb/tb_led_flash.sv
// Bench for led_flash: directed scenarios plus random fs/rst traffic, checked
// against an elapsed-time model of the flash run.
module tb_led_flash;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, fs_a = 1'b0, fd_a;
    logic       rst_b = 1'b1, fs_b = 1'b0, fd_b;
    logic [3:0] led_a, led_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    led_flash #(.TIME_ON(32'd3), .TIME_OFF(32'd2), .NUM_FLASH(2), .LED_W(4)) dut_a (
        .clk(clk), .rst(rst_a), .fs(fs_a), .fd(fd_a), .led(led_a)
    );

    led_flash #(.TIME_ON(32'd1), .TIME_OFF(32'd1), .NUM_FLASH(6), .LED_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .fs(fs_b), .fd(fd_b), .led(led_b)
    );

    // Model: mode 0 idle, 1 running (e = cycles since start edge), 2 done.
    int ma_mode = 0, ma_e = 0, mb_mode = 0, mb_e = 0;

    function automatic void mstep(input logic r, input logic f, input int run_len,
                                  inout int mode, inout int e);
        if (r) begin
            mode = 0; e = 0;
        end else if (mode == 0) begin
            if (f) begin mode = 1; e = 0; end
        end else if (mode == 1) begin
            if (!f) mode = 0;
            else begin
                e++;
                if (e == run_len) mode = 2;
            end
        end else if (!f) begin
            mode = 0;
        end
    endfunction

    function automatic logic [3:0] mled(input int mode, input int e, input int t_on, input int t_off);
        int p;
        p = t_on + t_off;
        if (mode == 1 && (e % p) < t_on) return 4'(1 << ((e / p) % 4));
        return 4'b0000;
    endfunction

    always @(posedge clk) begin
        mstep(rst_a, fs_a, 2 * 5, ma_mode, ma_e);
        mstep(rst_b, fs_b, 6 * 2, mb_mode, mb_e);
    end

    logic [3:0] ea_led, eb_led;
    logic       ea_fd, eb_fd;
    always_comb begin
        ea_led = mled(ma_mode, ma_e, 3, 2);
        eb_led = mled(mb_mode, mb_e, 1, 1);
        ea_fd  = (ma_mode == 2);
        eb_fd  = (mb_mode == 2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1; fs_a = 1'b0;
        tick();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; fs_a = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_chk++;
            if (led_a !== 4'b0000 || fd_a !== 1'b0) begin
                n_fail++;
                $display("FAIL reset c%0d led=%b fd=%b expected led=0000 fd=0", c, led_a, fd_a);
            end
        end
        rst_a = 1'b0;
        tick();
        n_chk++;
        if (led_a !== 4'b0001 || fd_a !== 1'b0 || ea_led !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_release led=%b fd=%b expected led=0001 fd=0", led_a, fd_a);
        end
        reset_a();
    endtask

    task automatic test_full_run();
        logic [3:0] lit [0:10];
        lit = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        reset_a();
        fs_a = 1'b1;
        tick();
        for (int c = 1; c <= 11; c++) begin
            n_chk++;
            if (led_a !== lit[c-1] || led_a !== ea_led || fd_a !== (c == 11) || fd_a !== ea_fd) begin
                n_fail++;
                $display("FAIL full_run c%0d led=%b fd=%b expected led=%b fd=%b",
                         c, led_a, fd_a, lit[c-1], (c == 11));
            end
            if (c < 11) tick();
        end
        tick();
        n_chk++;
        if (fd_a !== 1'b1 || led_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL full_run c12 led=%b fd=%b expected led=0000 fd=1", led_a, fd_a);
        end
        fs_a = 1'b0;
        tick();
        n_chk++;
        if (fd_a !== 1'b0 || led_a !== 4'b0000 || ea_fd !== 1'b0) begin
            n_fail++;
            $display("FAIL full_run c13 led=%b fd=%b expected led=0000 fd=0", led_a, fd_a);
        end
    endtask

    task automatic test_abort();
        reset_a();
        fs_a = 1'b1;
        tick();
        for (int c = 1; c < 7; c++) tick();
        n_chk++;
        if (led_a !== 4'b0010 || led_a !== ea_led) begin
            n_fail++;
            $display("FAIL abort_c7 led=%b expected led=0010", led_a);
        end
        fs_a = 1'b0;
        for (int c = 8; c < 28; c++) begin
            tick();
            n_chk++;
            if (led_a !== 4'b0000 || fd_a !== 1'b0 || ea_fd !== 1'b0) begin
                n_fail++;
                $display("FAIL abort c%0d led=%b fd=%b expected led=0000 fd=0", c, led_a, fd_a);
            end
        end
    endtask

    task automatic test_held_done();
        reset_a();
        fs_a = 1'b1;
        tick();
        for (int c = 1; c < 11; c++) tick();
        for (int c = 11; c < 22; c++) begin
            n_chk++;
            if (fd_a !== 1'b1 || led_a !== 4'b0000 || ea_fd !== 1'b1) begin
                n_fail++;
                $display("FAIL held_done c%0d led=%b fd=%b expected led=0000 fd=1", c, led_a, fd_a);
            end
            tick();
        end
        fs_a = 1'b0;
        tick();
        n_chk++;
        if (fd_a !== 1'b0) begin
            n_fail++;
            $display("FAIL held_drop fd=%b expected fd=0", fd_a);
        end
        fs_a = 1'b1;
        tick();
        n_chk++;
        if (led_a !== 4'b0001 || fd_a !== 1'b0) begin
            n_fail++;
            $display("FAIL held_retrigger led=%b fd=%b expected led=0001 fd=0", led_a, fd_a);
        end
    endtask

    task automatic test_reset_mid();
        reset_a();
        fs_a = 1'b1;
        tick();
        for (int c = 1; c < 4; c++) tick();
        rst_a = 1'b1;
        tick();
        n_chk++;
        if (led_a !== 4'b0000 || fd_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid c5 led=%b fd=%b expected led=0000 fd=0", led_a, fd_a);
        end
        rst_a = 1'b0;
        tick();
        n_chk++;
        if (led_a !== 4'b0001 || led_a !== ea_led) begin
            n_fail++;
            $display("FAIL reset_mid_restart led=%b expected led=0001", led_a);
        end
        tick();
        tick();
        tick();
        n_chk++;
        if (led_a !== 4'b0000 || led_a !== ea_led) begin
            n_fail++;
            $display("FAIL reset_mid_off led=%b expected led=0000", led_a);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] seq [0:5];
        logic [3:0] exp;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst_b = 1'b1; fs_b = 1'b0;
        tick();
        rst_b = 1'b0; fs_b = 1'b1;
        tick();
        for (int c = 1; c <= 13; c++) begin
            exp = (c <= 12 && (c % 2) == 1) ? seq[(c-1)/2] : 4'b0000;
            n_chk++;
            if (led_b !== exp || led_b !== eb_led || fd_b !== (c == 13) || fd_b !== eb_fd) begin
                n_fail++;
                $display("FAIL wrap c%0d led=%b fd=%b expected led=%b fd=%b",
                         c, led_b, fd_b, exp, (c == 13));
            end
            if (c < 13) tick();
        end
        fs_b = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) fs_a = ~fs_a;
            if ($urandom_range(0, 24) == 0) fs_b = ~fs_b;
            if (fd_a && $urandom_range(0, 2) == 0) fs_a = 1'b0;
            if (fd_b && $urandom_range(0, 2) == 0) fs_b = 1'b0;
            rst_a = ($urandom_range(0, 149) == 0);
            rst_b = ($urandom_range(0, 149) == 0);
            tick();
            n_chk++;
            if (led_a !== ea_led || fd_a !== ea_fd || led_b !== eb_led || fd_b !== eb_fd) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random i%0d a:led=%b fd=%b exp %b/%b b:led=%b fd=%b exp %b/%b",
                             i, led_a, fd_a, ea_led, ea_fd, led_b, fd_b, eb_led, eb_fd);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_abort();
        test_held_done();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
